uop_decode_stage: RTL and testbench
===================================

# uop_decode_stage

Second stage of the in-order front end of the microcode unit. It takes a two-wide bundle of fetched micro-ops from the fetch stage, classifies each op, and allocates physical destination registers from an internal free-list. It presents a registered decoded bundle, with pregs and an execute count, to the issue stage under the valid/stalled/enabled pipeline handshake.

## Interface
- NUM_PREGS, 64: physical register count; PREG_W = $clog2(NUM_PREGS).
- BRANCH_TAG_W, 3: branch tag width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- clear  in  1  flush; drops held bundle.
- prev_valid  in  1  fetch output valid.
- enabled  in  1  this stage accepts input this cycle (driven as prev_valid && !stalled).
- next_enabled  in  1  issue stage consumes this stage's output this cycle.
- next_stalled  in  1  issue stage stalled.
- instruction_1/2  in  32+BRANCH_TAG_W  {instruction[31:0], branch_tag}.
- free_valid  in  2  return-register strobes.
- free_preg_0/1  in  PREG_W  registers returned by commit.
- stalled  out  1  combinational stall.
- valid  out  1  decoded bundle valid.
- decoded_1/2  out  36+BRANCH_TAG_W  {is_noop, rs_station[1:0], has_dest, rd[4:0], rs1[4:0], rs2[4:0], imm[15:0], branch_tag}.
- preg1/2  out  PREG_W  allocated destination preg; 0 if none.
- num_execute  out  2  count of ops with rs_station != 0.

## Operation
- Field extraction: opcode = instr[31:26], rd = [25:21], rs1 = [20:16], rs2 = [15:11], imm = [15:0].
- Opcode classes:
  - 0x00: NOP, is_noop=1, station 0.
  - 0x01–0x0F: ALU, station 1, writes rd.
  - 0x10–0x13: load, station 2, writes rd.
  - 0x14–0x17: store, station 2, no dest.
  - 0x18–0x1F: branch, station 3, no dest.
  - 0x20–0x3F: illegal, decoded as NOP.
- has_dest = class writes rd && rd != 0.
- Free-list is a NUM_PREGS-bit bitmap plus a free count.
  - Reset: pregs 0–31 busy (identity map of architectural regs), 32..NUM_PREGS-1 free.
- Allocation on enabled:
  - instruction_1 takes the lowest free preg if has_dest.
  - instruction_2 takes the next lowest free preg if has_dest.
  - Allocated bits are cleared; preg outputs latch the allocated numbers.
- need = has_dest_1 + has_dest_2 for the incoming bundle.
- stalled = (valid && next_stalled) || (prev_valid && need > free_count).
- Register update, in priority order:
  - reset: all outputs 0, valid 0, bitmap re-initialised.
  - else clear: valid 0. Pregs held by the dropped bundle (when valid and has_dest) are set free. No allocation this cycle.
  - else enabled: latch decoded bundle, pregs and num_execute; valid 1.
  - else next_enabled: valid 0; data holds.
- Frees: each set free_valid bit sets its preg's bitmap bit at the clock edge.
  - A preg freed in cycle N is not allocatable until cycle N+1.
  - Freeing an already-free preg has no effect; the count is unchanged.
  - Freeing preg 0–31 is legal.
- free_count is updated with +frees −allocs in the same edge and never exceeds NUM_PREGS.

## Timing
- Latency 1 cycle: a bundle accepted at edge N is valid after edge N.
- stalled is combinational from valid, next_stalled, prev_valid, the instruction inputs and free_count. It has no path from enabled or next_enabled, so there is no loop.
- enabled and next_enabled in the same cycle: the new bundle replaces the old one and valid stays 1.
- With free_count exactly equal to need, the bundle is accepted and free_count becomes 0.
- Reset asserted mid-stream overrides clear, enabled and frees.

## Configuration
- UOP_DECODE_TRACE_EN defined: each edge where valid is 1 and not both ops are is_noop, the stage prints "decoded - %x %x %x %x" with rs_station_1, rs_station_2, preg1, preg2.
- UOP_DECODE_TRACE_EN undefined: no simulation output; logic is identical.

## Test plan
- Reset, then ALU 0x04 rd=3 paired with NOP, with prev_valid=1 and enabled=1 -> next cycle: valid=1, preg1=32, preg2=0, stations 1/0, num_execute=1.
- Two loads, both rd≠0, accepted back-to-back -> pregs 32/33, then 34/35; free_count drops by 4.
- Hold next_stalled=1 with valid=1 -> stalled=1. Output held until next_enabled; with no new input, valid then drops to 0.
- Drain the free-list to 1 free preg, then offer two dest-writing ops -> stalled=1, no allocation. Return one preg via free_valid -> accepted on the following cycle.
- clear while holding a bundle with pregs 40/41 -> valid=0, and pregs 40/41 are allocatable next (lowest-first).
- Store + branch bundle -> has_dest 0/0, preg1=preg2=0, num_execute=2, free_count unchanged.

Source files
------------

// File: rtl/uop_decode_stage.sv
// Micro-op decode stage: classifies a two-wide fetch bundle and allocates destination pregs from a bitmap free-list.
// Optional trace output is enabled by defining UOP_DECODE_TRACE_EN.
module uop_decode_stage #(
    parameter int NUM_PREGS    = 64,
    parameter int BRANCH_TAG_W = 3,
    localparam int PREG_W  = $clog2(NUM_PREGS),
    localparam int INSTR_W = 32 + BRANCH_TAG_W,
    localparam int DEC_W   = 36 + BRANCH_TAG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               prev_valid,
    input  logic               enabled,
    input  logic               next_enabled,
    input  logic               next_stalled,
    input  logic [INSTR_W-1:0] instruction_1,
    input  logic [INSTR_W-1:0] instruction_2,
    input  logic [1:0]         free_valid,
    input  logic [PREG_W-1:0]  free_preg_0,
    input  logic [PREG_W-1:0]  free_preg_1,
    output logic               stalled,
    output logic               valid,
    output logic [DEC_W-1:0]   decoded_1,
    output logic [DEC_W-1:0]   decoded_2,
    output logic [PREG_W-1:0]  preg1,
    output logic [PREG_W-1:0]  preg2,
    output logic [1:0]         num_execute
);
    localparam int HD_BIT   = BRANCH_TAG_W + 31;
    localparam int ST_LO    = BRANCH_TAG_W + 32;
    localparam int NOOP_BIT = BRANCH_TAG_W + 34;

    logic [NUM_PREGS-1:0] free_map, alloc_mask, add_mask, next_map;
    logic [PREG_W:0]      free_count, next_count;
    logic [DEC_W-1:0]     dec_in_1, dec_in_2;
    logic                 hd_1, hd_2;
    logic [1:0]           need;
    logic                 first_ok, second_ok;
    logic [PREG_W-1:0]    first_idx, second_idx, alloc_1, alloc_2;
    logic [1:0]           exec_in;

    // Decoded word carries one reserved zero MSB above is_noop.
    function automatic logic [DEC_W-1:0] decode(input logic [INSTR_W-1:0] ins);
        logic [31:0] w;
        logic [5:0]  op;
        logic        noop, writes, hd;
        logic [1:0]  st;
        w      = ins[INSTR_W-1:BRANCH_TAG_W];
        op     = w[31:26];
        noop   = 1'b0;
        writes = 1'b0;
        st     = 2'd0;
        if (op == 6'h00 || op[5]) begin
            noop = 1'b1;
        end else if (op <= 6'h0F) begin
            st     = 2'd1;
            writes = 1'b1;
        end else if (op <= 6'h13) begin
            st     = 2'd2;
            writes = 1'b1;
        end else if (op <= 6'h17) begin
            st = 2'd2;
        end else begin
            st = 2'd3;
        end
        hd = writes && (w[25:21] != 5'd0);
        return {1'b0, noop, st, hd, w[25:21], w[20:16], w[15:11], w[15:0],
                ins[BRANCH_TAG_W-1:0]};
    endfunction

    always_comb begin
        dec_in_1 = decode(instruction_1);
        dec_in_2 = decode(instruction_2);
        hd_1     = dec_in_1[HD_BIT];
        hd_2     = dec_in_2[HD_BIT];
        need     = {1'b0, hd_1} + {1'b0, hd_2};
        exec_in  = {1'b0, |dec_in_1[ST_LO+1:ST_LO]} + {1'b0, |dec_in_2[ST_LO+1:ST_LO]};
        stalled  = (valid && next_stalled) ||
                   (prev_valid && ((PREG_W+1)'(need) > free_count));
    end

    always_comb begin
        first_ok   = 1'b0;
        second_ok  = 1'b0;
        first_idx  = '0;
        second_idx = '0;
        for (int unsigned i = 0; i < NUM_PREGS; i++) begin
            if (free_map[i]) begin
                if (!first_ok) begin
                    first_ok  = 1'b1;
                    first_idx = PREG_W'(i);
                end else if (!second_ok) begin
                    second_ok  = 1'b1;
                    second_idx = PREG_W'(i);
                end
            end
        end
    end

    // Op 2 takes the lowest free preg when op 1 needs none, otherwise the next lowest.
    always_comb begin
        alloc_1    = '0;
        alloc_2    = '0;
        alloc_mask = '0;
        add_mask   = '0;
        if (enabled && !clear) begin
            if (hd_1 && first_ok) begin
                alloc_1               = first_idx;
                alloc_mask[first_idx] = 1'b1;
            end
            if (hd_2 && hd_1 && second_ok) begin
                alloc_2                = second_idx;
                alloc_mask[second_idx] = 1'b1;
            end else if (hd_2 && !hd_1 && first_ok) begin
                alloc_2               = first_idx;
                alloc_mask[first_idx] = 1'b1;
            end
        end
        if (clear && valid && decoded_1[HD_BIT]) add_mask[preg1] = 1'b1;
        if (clear && valid && decoded_2[HD_BIT]) add_mask[preg2] = 1'b1;
        if (free_valid[0]) add_mask[free_preg_0] = 1'b1;
        if (free_valid[1]) add_mask[free_preg_1] = 1'b1;
        // Only bits that are currently busy count as new frees.
        add_mask   = add_mask & ~free_map;
        next_map   = (free_map & ~alloc_mask) | add_mask;
        next_count = free_count + (PREG_W+1)'($countones(add_mask))
                                - (PREG_W+1)'($countones(alloc_mask));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid       <= 1'b0;
            decoded_1   <= '0;
            decoded_2   <= '0;
            preg1       <= '0;
            preg2       <= '0;
            num_execute <= '0;
            for (int unsigned i = 0; i < NUM_PREGS; i++) free_map[i] <= (i >= 32);
            free_count  <= (PREG_W+1)'(NUM_PREGS - 32);
        end else begin
            free_map   <= next_map;
            free_count <= next_count;
            if (clear) begin
                valid <= 1'b0;
            end else if (enabled) begin
                valid       <= 1'b1;
                decoded_1   <= dec_in_1;
                decoded_2   <= dec_in_2;
                preg1       <= alloc_1;
                preg2       <= alloc_2;
                num_execute <= exec_in;
            end else if (next_enabled) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef UOP_DECODE_TRACE_EN
    always_ff @(posedge clk) begin
        if (valid && !(decoded_1[NOOP_BIT] && decoded_2[NOOP_BIT]))
            $display("decoded - %x %x %x %x", decoded_1[ST_LO+1:ST_LO],
                     decoded_2[ST_LO+1:ST_LO], preg1, preg2);
    end
`endif

endmodule

// File: tb/tb_uop_decode_stage.sv
// Directed self-checking bench for uop_decode_stage.
module tb_uop_decode_stage;
    localparam int NP = 64;
    localparam int TW = 3;
    localparam int PW = 6;
    localparam int IW = 32 + TW;
    localparam int DW = 36 + TW;

    logic          clk = 1'b0;
    logic          reset, clear, prev_valid, enabled, next_enabled, next_stalled;
    logic [IW-1:0] instruction_1, instruction_2;
    logic [1:0]    free_valid;
    logic [PW-1:0] free_preg_0, free_preg_1;
    logic          stalled, valid;
    logic [DW-1:0] decoded_1, decoded_2;
    logic [PW-1:0] preg1, preg2;
    logic [1:0]    num_execute;

    int checks = 0;
    int errors = 0;

    uop_decode_stage #(.NUM_PREGS(NP), .BRANCH_TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .prev_valid(prev_valid),
        .enabled(enabled), .next_enabled(next_enabled), .next_stalled(next_stalled),
        .instruction_1(instruction_1), .instruction_2(instruction_2),
        .free_valid(free_valid), .free_preg_0(free_preg_0), .free_preg_1(free_preg_1),
        .stalled(stalled), .valid(valid), .decoded_1(decoded_1), .decoded_2(decoded_2),
        .preg1(preg1), .preg2(preg2), .num_execute(num_execute)
    );

    always #5 clk = ~clk;

    // Handshake wiring as the neighbouring stages drive it.
    assign enabled      = prev_valid && !stalled;
    assign next_enabled = valid && !next_stalled;

    function automatic logic [IW-1:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [15:0] imm,
                                         input logic [TW-1:0] tag);
        return {op, rd, rs1, imm, tag};
    endfunction

    function automatic logic [DW-1:0] pack(input logic noop, input logic [1:0] st,
                                           input logic hd, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [15:0] imm,
                                           input logic [TW-1:0] tag);
        return {1'b0, noop, st, hd, rd, rs1, imm[15:11], imm, tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0; clear = 1'b0; prev_valid = 1'b0; next_stalled = 1'b0;
        free_valid = 2'b00; free_preg_0 = '0; free_preg_1 = '0;
        instruction_1 = '0; instruction_2 = '0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        reset = 1'b0;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (preg1 !== 6'd0 || preg2 !== 6'd0) begin errors++; $display("FAIL reset_pregs: got %0d/%0d expected 0/0", preg1, preg2); end
        checks++; if (decoded_1 !== '0 || num_execute !== 2'd0) begin errors++; $display("FAIL reset_data: got %h/%0d expected 0/0", decoded_1, num_execute); end
        checks++; if (dut.free_count !== 7'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", dut.free_count); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled: got %b expected 0", stalled); end
        reset = 1'b1;
    endtask

    task automatic test_alu_nop();
        reset_dut();
        instruction_1 = mk(6'h04, 5'd3, 5'd1, 16'h1234, 3'd5);
        instruction_2 = '0;
        prev_valid = 1'b1;
        tick();
        prev_valid = 1'b0;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b expected 1", valid); end
        checks++; if (preg1 !== 6'd32 || preg2 !== 6'd0) begin errors++; $display("FAIL alu_pregs: got %0d/%0d expected 32/0", preg1, preg2); end
        checks++; if (decoded_1 !== pack(1'b0, 2'd1, 1'b1, 5'd3, 5'd1, 16'h1234, 3'd5)) begin errors++; $display("FAIL alu_dec1: got %h expected %h", decoded_1, pack(1'b0, 2'd1, 1'b1, 5'd3, 5'd1, 16'h1234, 3'd5)); end
        checks++; if (decoded_2 !== pack(1'b1, 2'd0, 1'b0, 5'd0, 5'd0, 16'h0, 3'd0)) begin errors++; $display("FAIL alu_dec2: got %h expected %h", decoded_2, pack(1'b1, 2'd0, 1'b0, 5'd0, 5'd0, 16'h0, 3'd0)); end
        checks++; if (num_execute !== 2'd1) begin errors++; $display("FAIL alu_nexec: got %0d expected 1", num_execute); end
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL alu_drain: got %b expected 0", valid); end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        instruction_1 = mk(6'h10, 5'd5, 5'd2, 16'h0010, 3'd0);
        instruction_2 = mk(6'h11, 5'd6, 5'd2, 16'h0014, 3'd1);
        prev_valid = 1'b1;
        tick();
        checks++; if (valid !== 1'b1 || preg1 !== 6'd32 || preg2 !== 6'd33) begin errors++; $display("FAIL b2b_first: got v=%b %0d/%0d expected v=1 32/33", valid, preg1, preg2); end
        checks++; if (decoded_2 !== pack(1'b0, 2'd2, 1'b1, 5'd6, 5'd2, 16'h0014, 3'd1)) begin errors++; $display("FAIL b2b_dec2: got %h expected %h", decoded_2, pack(1'b0, 2'd2, 1'b1, 5'd6, 5'd2, 16'h0014, 3'd1)); end
        instruction_1 = mk(6'h12, 5'd7, 5'd3, 16'h0020, 3'd2);
        instruction_2 = mk(6'h13, 5'd8, 5'd3, 16'h0024, 3'd3);
        tick();
        prev_valid = 1'b0;
        checks++; if (valid !== 1'b1 || preg1 !== 6'd34 || preg2 !== 6'd35) begin errors++; $display("FAIL b2b_second: got v=%b %0d/%0d expected v=1 34/35", valid, preg1, preg2); end
        checks++; if (dut.free_count !== 7'd28) begin errors++; $display("FAIL b2b_count: got %0d expected 28", dut.free_count); end
        tick();
    endtask

    task automatic test_stall();
        reset_dut();
        instruction_1 = mk(6'h01, 5'd1, 5'd0, 16'h0, 3'd0);
        instruction_2 = '0;
        prev_valid = 1'b1;
        tick();
        next_stalled = 1'b1;
        instruction_1 = mk(6'h02, 5'd2, 5'd0, 16'h0, 3'd0);
        #1;
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_comb: got %b expected 1", stalled); end
        tick(); tick();
        checks++; if (valid !== 1'b1 || preg1 !== 6'd32) begin errors++; $display("FAIL stall_hold: got v=%b p=%0d expected v=1 p=32", valid, preg1); end
        checks++; if (dut.free_count !== 7'd31) begin errors++; $display("FAIL stall_count: got %0d expected 31", dut.free_count); end
        next_stalled = 1'b0;
        prev_valid = 1'b0;
        tick();
        checks++; if (valid !== 1'b0 || preg1 !== 6'd32) begin errors++; $display("FAIL stall_release: got v=%b p=%0d expected v=0 p=32", valid, preg1); end
    endtask

    task automatic test_drain();
        reset_dut();
        instruction_1 = mk(6'h01, 5'd1, 5'd0, 16'h0, 3'd0);
        instruction_2 = mk(6'h02, 5'd2, 5'd0, 16'h0, 3'd0);
        prev_valid = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        checks++; if (preg1 !== 6'd60 || preg2 !== 6'd61) begin errors++; $display("FAIL drain_pregs: got %0d/%0d expected 60/61", preg1, preg2); end
        instruction_2 = '0;
        tick();
        checks++; if (preg1 !== 6'd62 || dut.free_count !== 7'd1) begin errors++; $display("FAIL drain_last: got p=%0d c=%0d expected p=62 c=1", preg1, dut.free_count); end
        instruction_2 = mk(6'h03, 5'd4, 5'd0, 16'h0, 3'd0);
        #1;
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL drain_stall: got %b expected 1", stalled); end
        tick();
        checks++; if (valid !== 1'b0 || dut.free_count !== 7'd1) begin errors++; $display("FAIL drain_noalloc: got v=%b c=%0d expected v=0 c=1", valid, dut.free_count); end
        free_valid = 2'b01;
        free_preg_0 = 6'd10;
        tick();
        free_valid = 2'b00;
        checks++; if (stalled !== 1'b0 || dut.free_count !== 7'd2) begin errors++; $display("FAIL drain_freed: got s=%b c=%0d expected s=0 c=2", stalled, dut.free_count); end
        tick();
        prev_valid = 1'b0;
        checks++; if (valid !== 1'b1 || preg1 !== 6'd10 || preg2 !== 6'd63) begin errors++; $display("FAIL drain_accept: got v=%b %0d/%0d expected v=1 10/63", valid, preg1, preg2); end
        checks++; if (dut.free_count !== 7'd0) begin errors++; $display("FAIL drain_zero: got %0d expected 0", dut.free_count); end
        tick();
    endtask

    task automatic test_clear();
        reset_dut();
        instruction_1 = mk(6'h05, 5'd9, 5'd1, 16'h0, 3'd0);
        instruction_2 = mk(6'h06, 5'd10, 5'd1, 16'h0, 3'd0);
        prev_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        tick();
        prev_valid = 1'b0;
        next_stalled = 1'b1;
        checks++; if (valid !== 1'b1 || preg1 !== 6'd40 || preg2 !== 6'd41) begin errors++; $display("FAIL clear_setup: got v=%b %0d/%0d expected v=1 40/41", valid, preg1, preg2); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        next_stalled = 1'b0;
        checks++; if (valid !== 1'b0 || dut.free_count !== 7'd24) begin errors++; $display("FAIL clear_drop: got v=%b c=%0d expected v=0 c=24", valid, dut.free_count); end
        prev_valid = 1'b1;
        tick();
        prev_valid = 1'b0;
        next_stalled = 1'b1;
        checks++; if (valid !== 1'b1 || preg1 !== 6'd40 || preg2 !== 6'd41) begin errors++; $display("FAIL clear_realloc: got v=%b %0d/%0d expected v=1 40/41", valid, preg1, preg2); end
        // Reset wins over clear and frees on the same edge.
        reset = 1'b0;
        clear = 1'b1;
        free_valid = 2'b11;
        free_preg_0 = 6'd5;
        free_preg_1 = 6'd6;
        tick();
        reset = 1'b1; clear = 1'b0; free_valid = 2'b00; next_stalled = 1'b0;
        checks++; if (valid !== 1'b0 || preg1 !== 6'd0 || dut.free_count !== 7'd32) begin errors++; $display("FAIL reset_override: got v=%b p=%0d c=%0d expected v=0 p=0 c=32", valid, preg1, dut.free_count); end
    endtask

    task automatic test_store_branch();
        reset_dut();
        instruction_1 = mk(6'h14, 5'd7, 5'd2, 16'h0abc, 3'd1);
        instruction_2 = mk(6'h18, 5'd2, 5'd3, 16'hfff0, 3'd6);
        prev_valid = 1'b1;
        tick();
        checks++; if (decoded_1 !== pack(1'b0, 2'd2, 1'b0, 5'd7, 5'd2, 16'h0abc, 3'd1)) begin errors++; $display("FAIL sb_dec1: got %h expected %h", decoded_1, pack(1'b0, 2'd2, 1'b0, 5'd7, 5'd2, 16'h0abc, 3'd1)); end
        checks++; if (decoded_2 !== pack(1'b0, 2'd3, 1'b0, 5'd2, 5'd3, 16'hfff0, 3'd6)) begin errors++; $display("FAIL sb_dec2: got %h expected %h", decoded_2, pack(1'b0, 2'd3, 1'b0, 5'd2, 5'd3, 16'hfff0, 3'd6)); end
        checks++; if (preg1 !== 6'd0 || preg2 !== 6'd0 || num_execute !== 2'd2) begin errors++; $display("FAIL sb_pregs: got %0d/%0d n=%0d expected 0/0 n=2", preg1, preg2, num_execute); end
        checks++; if (dut.free_count !== 7'd32) begin errors++; $display("FAIL sb_count: got %0d expected 32", dut.free_count); end
        instruction_1 = mk(6'h25, 5'd4, 5'd1, 16'h1111, 3'd2);
        instruction_2 = mk(6'h0F, 5'd0, 5'd1, 16'h2222, 3'd3);
        tick();
        prev_valid = 1'b0;
        checks++; if (decoded_1 !== pack(1'b1, 2'd0, 1'b0, 5'd4, 5'd1, 16'h1111, 3'd2)) begin errors++; $display("FAIL illegal_dec: got %h expected %h", decoded_1, pack(1'b1, 2'd0, 1'b0, 5'd4, 5'd1, 16'h1111, 3'd2)); end
        checks++; if (decoded_2 !== pack(1'b0, 2'd1, 1'b0, 5'd0, 5'd1, 16'h2222, 3'd3)) begin errors++; $display("FAIL rd0_dec: got %h expected %h", decoded_2, pack(1'b0, 2'd1, 1'b0, 5'd0, 5'd1, 16'h2222, 3'd3)); end
        checks++; if (num_execute !== 2'd1 || preg2 !== 6'd0) begin errors++; $display("FAIL rd0_nexec: got n=%0d p=%0d expected n=1 p=0", num_execute, preg2); end
        free_valid = 2'b11;
        free_preg_0 = 6'd45;
        free_preg_1 = 6'd45;
        tick();
        checks++; if (dut.free_count !== 7'd32) begin errors++; $display("FAIL free_dup: got %0d expected 32", dut.free_count); end
        free_preg_0 = 6'd0;
        free_preg_1 = 6'd0;
        tick();
        free_valid = 2'b00;
        checks++; if (dut.free_count !== 7'd33) begin errors++; $display("FAIL free_low: got %0d expected 33", dut.free_count); end
    endtask

    initial begin
        test_reset();
        test_alu_nop();
        test_back_to_back();
        test_stall();
        test_drain();
        test_clear();
        test_store_branch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
